// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency word memory between instruction fetch and the
// load/store unit, with data priority, an IF starvation guard and flush of in-flight fetches.
module mem_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               if_req,
    input  logic [ADDR_W-1:0]                  if_addr,
    input  logic                               if_flush,
    output logic                               if_gnt,
    output logic                               if_rvalid,
    output logic [DATA_W-1:0]                  if_rdata,
    input  logic                               d_req,
    input  logic                               d_we,
    input  logic [ADDR_W-1:0]                  d_addr,
    input  logic [DATA_W-1:0]                  d_wdata,
    output logic                               d_gnt,
    output logic                               d_rvalid,
    output logic [DATA_W-1:0]                  d_rdata,
    output logic                               mem_en,
    output logic                               mem_we,
    output logic [ADDR_W-1:0]                  mem_addr,
    output logic [DATA_W-1:0]                  mem_wdata,
    input  logic [DATA_W-1:0]                  mem_rdata,
    output logic [$clog2(STARVE_MAX+1)-1:0]    starve_cnt
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CMAX = CW'(STARVE_MAX);

    logic               force_if;
    logic [MEM_LAT-1:0] tag_v;
    logic [MEM_LAT-1:0] tag_d;
    logic [MEM_LAT-1:0] live;
    logic               if_hit;
    logic               d_hit;

    always_comb begin
        force_if  = if_req && starve_cnt == CMAX;
        d_gnt     = d_req && !force_if;
        if_gnt    = if_req && !d_gnt;
        mem_en    = if_gnt || d_gnt;
        mem_we    = d_gnt && d_we;
        mem_addr  = d_gnt ? d_addr : (if_gnt ? if_addr : '0);
        mem_wdata = d_gnt ? d_wdata : '0;
        // a flush kills every IF-owned tag already in the pipe, tail included
        live      = tag_v & ~({MEM_LAT{if_flush}} & ~tag_d);
        if_hit    = live[MEM_LAT-1] && !tag_d[MEM_LAT-1];
        d_hit     = live[MEM_LAT-1] && tag_d[MEM_LAT-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve_cnt <= '0;
        else if (if_gnt)
            starve_cnt <= '0;
        else if (if_req && starve_cnt != CMAX)
            starve_cnt <= starve_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v     <= '0;
            tag_d     <= '0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            tag_v[0]  <= mem_en && !mem_we;
            tag_d[0]  <= d_gnt;
            for (int i = 1; i < MEM_LAT; i++) begin
                tag_v[i] <= live[i-1];
                tag_d[i] <= tag_d[i-1];
            end
            if_rvalid <= if_hit;
            d_rvalid  <= d_hit;
            if (if_hit)
                if_rdata <= mem_rdata;
            if (d_hit)
                d_rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, starvation, responses, flush and reset
module tb_mem_port_arbiter;
  logic clk;
  logic rst_n;
  logic if_req;
  logic [9:0] if_addr;
  logic if_flush;
  logic d_req;
  logic d_we;
  logic [9:0] d_addr;
  logic [31:0] d_wdata;
  logic if_gnt_1, if_rvalid_1, d_gnt_1, d_rvalid_1, mem_en_1, mem_we_1;
  logic [31:0] if_rdata_1, d_rdata_1, mem_wdata_1, mem_rdata_1;
  logic [9:0] mem_addr_1;
  logic [2:0] starve_cnt_1;
  logic if_gnt_2, if_rvalid_2, d_gnt_2, d_rvalid_2, mem_en_2, mem_we_2;
  logic [31:0] if_rdata_2, d_rdata_2, mem_wdata_2, mem_rdata_2;
  logic [9:0] mem_addr_2;
  logic [2:0] starve_cnt_2;
  logic [31:0] mem [0:1023];
  logic [31:0] r2a;
  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u1 (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt_1), .if_rvalid(if_rvalid_1), .if_rdata(if_rdata_1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt_1), .d_rvalid(d_rvalid_1), .d_rdata(d_rdata_1),
    .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
    .mem_rdata(mem_rdata_1), .starve_cnt(starve_cnt_1));

  mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) u2 (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt_2), .if_rvalid(if_rvalid_2), .if_rdata(if_rdata_2),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt_2), .d_rvalid(d_rvalid_2), .d_rdata(d_rdata_2),
    .mem_en(mem_en_2), .mem_we(mem_we_2), .mem_addr(mem_addr_2), .mem_wdata(mem_wdata_2),
    .mem_rdata(mem_rdata_2), .starve_cnt(starve_cnt_2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] <= 32'hA000_0000 | i;
    mem[5] <= 32'h11;
  end

  always @(posedge clk) begin
    if (mem_en_1 && mem_we_1) mem[mem_addr_1] <= mem_wdata_1;
    mem_rdata_1 <= mem[mem_addr_1];
    r2a <= mem[mem_addr_2];
    mem_rdata_2 <= r2a;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic nx;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; if_req = 0; if_addr = 0; if_flush = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    #2;
    checks++; if (starve_cnt_1 !== 3'd0) begin errors++; $error("FAIL reset_starve %0h", starve_cnt_1); end
    checks++; if (if_rvalid_1 !== 1'b0) begin errors++; $error("FAIL reset_if_rvalid"); end
    nx; nx;
    rst_n = 1'b1;
    smp;
    checks++; if (mem_en_1 !== 1'b0) begin errors++; $error("FAIL idle_mem_en"); end
    checks++; if (mem_addr_1 !== 10'd0) begin errors++; $error("FAIL idle_mem_addr %0h", mem_addr_1); end
    nx;
    if_req = 1; if_addr = 10'd5;
    smp;
    checks++; if (if_gnt_1 !== 1'b1) begin errors++; $error("FAIL ifrd_gnt"); end
    checks++; if (d_gnt_1 !== 1'b0) begin errors++; $error("FAIL ifrd_d_gnt"); end
    checks++; if (mem_en_1 !== 1'b1) begin errors++; $error("FAIL ifrd_mem_en"); end
    checks++; if (mem_addr_1 !== 10'd5) begin errors++; $error("FAIL ifrd_mem_addr %0h", mem_addr_1); end
    nx;
    if_req = 0;
    smp;
    checks++; if (if_rvalid_1 !== 1'b0) begin errors++; $error("FAIL ifrd_c1_rvalid"); end
    nx;
    smp;
    checks++; if (if_rvalid_1 !== 1'b1) begin errors++; $error("FAIL ifrd_c2_rvalid"); end
    checks++; if (if_rdata_1 !== 32'h11) begin errors++; $error("FAIL ifrd_c2_rdata %0h", if_rdata_1); end
    checks++; if (d_rvalid_1 !== 1'b0) begin errors++; $error("FAIL ifrd_c2_d_rvalid"); end
    nx;
    smp;
    checks++; if (if_rvalid_1 !== 1'b0) begin errors++; $error("FAIL ifrd_c3_rvalid"); end
    checks++; if (if_rdata_1 !== 32'h11) begin errors++; $error("FAIL ifrd_c3_hold %0h", if_rdata_1); end
    nx; nx;
    if_req = 1; if_addr = 10'd9; d_req = 1; d_we = 0; d_addr = 10'd3;
    for (int k = 0; k < 4; k++) begin
      smp;
      checks++; if (d_gnt_1 !== 1'b1) begin errors++; $error("FAIL starve_d_gnt %0d", k); end
      checks++; if (if_gnt_1 !== 1'b0) begin errors++; $error("FAIL starve_if_gnt %0d", k); end
      checks++; if (starve_cnt_1 !== 3'(k)) begin errors++; $error("FAIL starve_cnt %0d %0h", k, starve_cnt_1); end
      nx;
    end
    smp;
    checks++; if (starve_cnt_1 !== 3'd4) begin errors++; $error("FAIL starve_cnt_max %0h", starve_cnt_1); end
    checks++; if (if_gnt_1 !== 1'b1) begin errors++; $error("FAIL starve_force_if"); end
    checks++; if (d_gnt_1 !== 1'b0) begin errors++; $error("FAIL starve_force_d"); end
    checks++; if (mem_addr_1 !== 10'd9) begin errors++; $error("FAIL starve_force_addr %0h", mem_addr_1); end
    nx;
    smp;
    checks++; if (starve_cnt_1 !== 3'd0) begin errors++; $error("FAIL starve_clear %0h", starve_cnt_1); end
    checks++; if (d_gnt_1 !== 1'b1) begin errors++; $error("FAIL starve_d_resume"); end
    nx;
    if_req = 0; d_req = 0;
    smp;
    checks++; if (starve_cnt_1 !== 3'd1) begin errors++; $error("FAIL starve_cnt_one %0h", starve_cnt_1); end
    nx;
    smp;
    checks++; if (starve_cnt_1 !== 3'd1) begin errors++; $error("FAIL starve_hold %0h", starve_cnt_1); end
    nx; nx; nx;
    d_req = 1; d_we = 1; d_addr = 10'd7; d_wdata = 32'hDEAD_BEEF;
    smp;
    checks++; if (d_gnt_1 !== 1'b1) begin errors++; $error("FAIL st_gnt"); end
    checks++; if (mem_we_1 !== 1'b1) begin errors++; $error("FAIL st_mem_we"); end
    checks++; if (mem_wdata_1 !== 32'hDEAD_BEEF) begin errors++; $error("FAIL st_mem_wdata %0h", mem_wdata_1); end
    checks++; if (mem_addr_1 !== 10'd7) begin errors++; $error("FAIL st_mem_addr %0h", mem_addr_1); end
    nx;
    d_we = 0;
    smp;
    checks++; if (mem_we_1 !== 1'b0) begin errors++; $error("FAIL ld_mem_we"); end
    checks++; if (mem_en_1 !== 1'b1) begin errors++; $error("FAIL ld_mem_en"); end
    nx;
    d_req = 0;
    smp;
    checks++; if (d_rvalid_1 !== 1'b0) begin errors++; $error("FAIL st_no_rvalid"); end
    nx;
    smp;
    checks++; if (d_rvalid_1 !== 1'b1) begin errors++; $error("FAIL ld_rvalid"); end
    checks++; if (d_rdata_1 !== 32'hDEAD_BEEF) begin errors++; $error("FAIL ld_rdata %0h", d_rdata_1); end
    checks++; if (if_rvalid_1 !== 1'b0) begin errors++; $error("FAIL ld_if_rvalid"); end
    nx;
    smp;
    checks++; if (d_rvalid_1 !== 1'b0) begin errors++; $error("FAIL ld_rvalid_once"); end
    nx; nx;
    if_req = 1; if_addr = 10'd1;
    smp;
    checks++; if (if_gnt_1 !== 1'b1) begin errors++; $error("FAIL fl_gnt0"); end
    nx;
    if_addr = 10'd2; if_flush = 1;
    smp;
    checks++; if (if_gnt_1 !== 1'b1) begin errors++; $error("FAIL fl_gnt1"); end
    checks++; if (mem_addr_1 !== 10'd2) begin errors++; $error("FAIL fl_addr1 %0h", mem_addr_1); end
    checks++; if (starve_cnt_1 !== 3'd0) begin errors++; $error("FAIL fl_starve_clr %0h", starve_cnt_1); end
    nx;
    if_req = 0; if_flush = 0;
    smp;
    checks++; if (if_rvalid_1 !== 1'b0) begin errors++; $error("FAIL fl_killed"); end
    nx;
    smp;
    checks++; if (if_rvalid_1 !== 1'b1) begin errors++; $error("FAIL fl_kept_rvalid"); end
    checks++; if (if_rdata_1 !== 32'hA000_0002) begin errors++; $error("FAIL fl_kept_rdata %0h", if_rdata_1); end
    nx; nx; nx; nx;
    d_req = 1; d_we = 0; d_addr = 10'd4;
    smp;
    checks++; if (d_gnt_2 !== 1'b1) begin errors++; $error("FAIL mx_d_gnt"); end
    nx;
    d_req = 0; if_req = 1; if_addr = 10'd6;
    smp;
    checks++; if (if_gnt_2 !== 1'b1) begin errors++; $error("FAIL mx_if_gnt"); end
    nx;
    if_req = 0; if_flush = 1;
    smp;
    checks++; if (d_rvalid_2 !== 1'b0) begin errors++; $error("FAIL mx_c2_d_rvalid"); end
    nx;
    if_flush = 0;
    smp;
    checks++; if (d_rvalid_2 !== 1'b1) begin errors++; $error("FAIL mx_d_rvalid"); end
    checks++; if (d_rdata_2 !== 32'hA000_0004) begin errors++; $error("FAIL mx_d_rdata %0h", d_rdata_2); end
    checks++; if (if_rvalid_2 !== 1'b0) begin errors++; $error("FAIL mx_c3_if_rvalid"); end
    nx;
    smp;
    checks++; if (if_rvalid_2 !== 1'b0) begin errors++; $error("FAIL mx_if_killed"); end
    checks++; if (d_rvalid_2 !== 1'b0) begin errors++; $error("FAIL mx_d_once"); end
    nx;
    smp;
    checks++; if (if_rvalid_2 !== 1'b0) begin errors++; $error("FAIL mx_if_killed2"); end
    nx; nx; nx;
    if_req = 1; d_req = 1; d_we = 0; d_addr = 10'd7;
    smp;
    checks++; if (d_gnt_1 !== 1'b1) begin errors++; $error("FAIL rs_d_gnt"); end
    nx;
    if_req = 0; d_req = 0;
    smp;
    checks++; if (starve_cnt_1 !== 3'd1) begin errors++; $error("FAIL rs_pre_cnt %0h", starve_cnt_1); end
    rst_n = 1'b0;
    #1;
    checks++; if (starve_cnt_1 !== 3'd0) begin errors++; $error("FAIL rs_cnt"); end
    checks++; if (starve_cnt_2 !== 3'd0) begin errors++; $error("FAIL rs_cnt2"); end
    checks++; if (d_rdata_1 !== 32'd0) begin errors++; $error("FAIL rs_d_rdata"); end
    checks++; if (if_rdata_1 !== 32'd0) begin errors++; $error("FAIL rs_if_rdata"); end
    checks++; if (d_rdata_2 !== 32'd0) begin errors++; $error("FAIL rs_d_rdata2"); end
    checks++; if (d_rvalid_1 !== 1'b0) begin errors++; $error("FAIL rs_d_rvalid"); end
    checks++; if (mem_en_1 !== 1'b0) begin errors++; $error("FAIL rs_mem_en"); end
    nx;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      smp;
      checks++; if ({if_rvalid_1, d_rvalid_1, if_rvalid_2, d_rvalid_2} !== 4'b0000) begin errors++; $error("FAIL rs_no_rvalid %0d", k); end
      nx;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port, fixed-latency word memory between two requesters of the 5-stage RV32I pipeline: instruction fetch (IF) and the MEM-stage load/store unit (D).
- Arbitrates one access per cycle with data priority and a starvation guard for IF.
- Tracks in-flight reads and routes each read response back to its owner.
- Drops stale fetch responses when the pipeline flushes on a taken branch.

Parameters:
ADDR_W, 10, word-address width (1024-word memory)
DATA_W, 32, data width
MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..4
STARVE_MAX, 4, consecutive denied IF-request cycles before IF is forced to win; legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  IF read request
if_addr  in  ADDR_W  IF word address
if_flush  in  1  taken-branch flush; discards IF responses already in flight
if_gnt  out  1  IF request accepted this cycle
if_rvalid  out  1  IF read data valid
if_rdata  out  DATA_W  IF read data
d_req  in  1  data request
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data word address
d_wdata  in  DATA_W  store data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  load data valid
d_rdata  out  DATA_W  load data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
starve_cnt  out  clog2(STARVE_MAX+1)  current IF starvation count (debug)

Behaviour:
- Reset (async, rst_n low): all registered state and outputs go to 0 immediately. This includes rvalid, rdata, starve_cnt and the in-flight tag pipeline. Responses in flight are lost; no rvalid appears after reset release for accesses issued before reset.
- Grant selection (combinational, same cycle as request):
  - force_if = if_req && starve_cnt == STARVE_MAX.
  - If force_if: IF wins.
  - Else if d_req: D wins.
  - Else if if_req: IF wins.
  - At most one of if_gnt / d_gnt is high. A requester holds req and addr stable until it sees gnt.
- Memory drive (combinational from the winner): mem_en = if_gnt | d_gnt.
  - mem_we = d_gnt & d_we.
  - mem_addr and mem_wdata come from the winner.
  - With no grant, mem_en = mem_we = 0 and addr/wdata = 0.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on each cycle where if_req && !if_gnt.
  - Clears to 0 on if_gnt.
  - Holds when if_req is low.
- In-flight tracking: a MEM_LAT-deep shift register of tags {valid, owner}, one entry per cycle.
  - On each edge the head entry is loaded with {mem_en && !mem_we, d_gnt ? D : IF}.
  - Writes never create a response.
- Response path (registered):
  - At the edge where the tail tag is valid, mem_rdata is captured into the owner's rdata and that owner's rvalid is set for exactly one cycle.
  - Read latency = MEM_LAT+1 cycles from grant cycle to rvalid.
  - rdata holds its last value when rvalid is low.
  - Back-to-back reads produce back-to-back rvalids.
- Flush:
  - if_flush high during a cycle clears the valid bit of every IF-owned tag issued in earlier cycles, including the tail entry being consumed at that edge. Those responses are never signalled.
  - An IF access granted in the same cycle as if_flush is kept.
  - D-owned tags are never affected.
  - if_flush does not change starve_cnt.
- Ordering: each requester receives responses in issue order; no reordering.
- Throughput: one access per cycle total; no bubble cycles between grants.

Test Plan:
- Reset: rst_n low with a read in flight; all outputs 0 immediately. Release; no rvalid for 5 cycles with no requests.
- IF read: MEM_LAT=1, mem[5]=0x00000011, if_req addr 5 in cycle 0 → if_gnt=1 and mem_en=1, mem_addr=5 in cycle 0 → if_rvalid=1, if_rdata=0x00000011 in cycle 2 only.
- Starvation: STARVE_MAX=4, if_req and d_req held high from cycle 0 → d_gnt in cycles 0–3, starve_cnt reaches 4, if_gnt in cycle 4, starve_cnt=0 in cycle 5, d_gnt resumes in cycle 5.
- Store then load: d write addr 7 data 0xDEADBEEF in cycle 0, d read addr 7 in cycle 1 → mem_we=1 in cycle 0 only, no d_rvalid for the store, d_rvalid with 0xDEADBEEF in cycle 3.
- Flush: IF reads addr 1 granted cycle 0 and addr 2 granted cycle 1, if_flush=1 in cycle 1 → no if_rvalid in cycle 2, if_rvalid with mem[2] in cycle 3.
- Mixed flush: D read in cycle 0, IF read in cycle 1, if_flush in cycle 2 (MEM_LAT=2) → d_rvalid in cycle 3; IF response suppressed.
